// File: rtl/gray_ptr_receiver.sv
// Receives a gray-coded pointer from a remote clock domain: two-flop synchronizer,
// single-bit-step checking, gray-to-binary decode and per-update advance reporting.
module gray_ptr_receiver #(
  parameter int counter_width = 4
) (
  input  logic                     clk,
  input  logic                     clr_in,
  input  logic [counter_width-1:0] gray_in,
  input  logic                     en_in,
  output logic [counter_width-1:0] gray_sync_out,
  output logic [counter_width-1:0] bin_out,
  output logic [counter_width-1:0] step_out,
  output logic                     step_valid_out,
  output logic                     err_out
);

  localparam int W = counter_width;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // s1/s2 form the synchronizer; s3 is only the previous s2 sample for the step check.
  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [W-1:0] gray_sync_q, gray_sync_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] step_q, step_d;
  logic         step_valid_q, step_valid_d;
  logic         err_q, err_d;

  logic [W-1:0] bin_dec;
  logic [W-1:0] sample_diff;
  logic         multi_bit;
  logic         changed;

  // Binary bit i is the XOR of gray bits i..W-1.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < W; i++) begin
      bin_dec[i] = ^(s2_q >> i);
    end
  end

  // More than one set bit <=> clearing the lowest set bit leaves something behind.
  always_comb begin
    sample_diff = s2_q ^ s3_q;
    multi_bit   = (sample_diff & (sample_diff - ONE)) != '0;
    changed     = s2_q != gray_sync_q;
  end

  // step_valid_out is a one-cycle pulse with no back-pressure: the local consumer
  // must take step_out in the cycle it is high. step_out only reloads on a real
  // pointer change, so a stalled pointer keeps the last advance visible.
  always_comb begin
    gray_sync_d  = gray_sync_q;
    bin_d        = bin_q;
    step_d       = step_q;
    step_valid_d = 1'b0;
    err_d        = err_q | multi_bit;
    if (en_in) begin
      gray_sync_d  = s2_q;
      bin_d        = bin_dec;
      step_valid_d = changed;
      if (changed) begin
        step_d = bin_dec - bin_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_in) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      gray_sync_q  <= '0;
      bin_q        <= '0;
      step_q       <= '0;
      step_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      s1_q         <= gray_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      gray_sync_q  <= gray_sync_d;
      bin_q        <= bin_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      err_q        <= err_d;
    end
  end

  assign gray_sync_out  = gray_sync_q;
  assign bin_out        = bin_q;
  assign step_out       = step_q;
  assign step_valid_out = step_valid_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Directed bench for gray_ptr_receiver: the driver pushes hand-derived expectations
// for each edge into a queue and a separate monitor pops and compares after the edge.
module tb_gray_ptr_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr_in;
  logic [W-1:0] gray_in;
  logic         en_in;
  logic [W-1:0] gray_sync_out;
  logic [W-1:0] bin_out;
  logic [W-1:0] step_out;
  logic         step_valid_out;
  logic         err_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] step;
    logic         sv;
    logic         err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gray_ptr_receiver #(.counter_width(W)) dut (
    .clk            (clk),
    .clr_in         (clr_in),
    .gray_in        (gray_in),
    .en_in          (en_in),
    .gray_sync_out  (gray_sync_out),
    .bin_out        (bin_out),
    .step_out       (step_out),
    .step_valid_out (step_valid_out),
    .err_out        (err_out)
  );

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs for the next posedge plus the outputs expected right after it.
  task automatic drive(input logic [W-1:0] g, input logic en, input logic clr,
                       input string nm, input logic [W-1:0] eb, input logic [W-1:0] es,
                       input logic esv, input logic eerr);
    exp_t e;
    @(negedge clk);
    gray_in = g;
    en_in   = en;
    clr_in  = clr;
    e.bin   = eb;
    e.step  = es;
    e.sv    = esv;
    e.err   = eerr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic clear_cycles(input int n, input logic [W-1:0] g, input string nm);
    for (int i = 0; i < n; i++) begin
      drive(g, 1'b1, 1'b1, nm, '0, '0, 1'b0, 1'b0);
    end
  endtask

  // Starting from a cleared receiver, walk binary 0..top (one step per edge, mod 2^W)
  // and then hold top for `hold` more edges. Output after edge j reflects the value
  // driven at edge j-2; the value driven at edge 0 is 0, same as the cleared state.
  task automatic ramp(input string nm, input int top, input int hold);
    logic [W-1:0] v;
    logic [W-1:0] eb;
    int src;
    for (int j = 0; j <= top + hold; j++) begin
      v   = (j < top) ? j[W-1:0] : top[W-1:0];
      src = j - 2;
      if (src < 1) begin
        drive(to_gray(v), 1'b1, 1'b0, nm, '0, '0, 1'b0, 1'b0);
      end else if (src <= top) begin
        eb = src[W-1:0];
        drive(to_gray(v), 1'b1, 1'b0, nm, eb, 4'd1, 1'b1, 1'b0);
      end else begin
        eb = top[W-1:0];
        drive(to_gray(v), 1'b1, 1'b0, nm, eb, 4'd1, 1'b0, 1'b0);
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (gray_sync_out !== to_gray(e.bin) || bin_out !== e.bin || step_out !== e.step ||
          step_valid_out !== e.sv || err_out !== e.err) begin
        errors++;
        $display("FAIL %s @%0t: got gsync=%b bin=%0d step=%0d sv=%b err=%b, expected gsync=%b bin=%0d step=%0d sv=%b err=%b",
                 nm, $time, gray_sync_out, bin_out, step_out, step_valid_out, err_out,
                 to_gray(e.bin), e.bin, e.step, e.sv, e.err);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    clr_in  = 1'b1;
    en_in   = 1'b0;
    gray_in = '0;

    // Reset with a live nonzero remote pointer (gray 0110 = bin 4), then release.
    // The 0 -> 0110 jump through s2/s3 is a two-bit change, so err_out rises too.
    clear_cycles(2, 4'b0110, "reset");
    drive(4'b0110, 1'b1, 1'b0, "rst_rel1", 4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'b0110, 1'b1, 1'b0, "rst_rel2", 4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'b0110, 1'b1, 1'b0, "rst_rel3", 4'd4, 4'd4, 1'b1, 1'b1);

    // Full gray walk 0..15, wrapping to 0,1: step_out = 1 throughout.
    clear_cycles(1, 4'b0000, "clr_count");
    ramp("count", 17, 2);

    // Stall at bin 7: valid drops, step_out keeps 1.
    clear_cycles(1, 4'b0000, "clr_stall");
    ramp("stall", 7, 3);

    // Enable gap while the remote pointer moves 5 -> 9.
    clear_cycles(1, 4'b0000, "clr_gate");
    ramp("gate_pre", 5, 2);
    drive(to_gray(4'd6), 1'b0, 1'b0, "gate_gap", 4'd5, 4'd1, 1'b0, 1'b0);
    drive(to_gray(4'd7), 1'b0, 1'b0, "gate_gap", 4'd5, 4'd1, 1'b0, 1'b0);
    drive(to_gray(4'd8), 1'b0, 1'b0, "gate_gap", 4'd5, 4'd1, 1'b0, 1'b0);
    drive(to_gray(4'd9), 1'b0, 1'b0, "gate_gap", 4'd5, 4'd1, 1'b0, 1'b0);
    drive(to_gray(4'd9), 1'b0, 1'b0, "gate_gap", 4'd5, 4'd1, 1'b0, 1'b0);
    drive(to_gray(4'd9), 1'b1, 1'b0, "gate_reen", 4'd9, 4'd4, 1'b1, 1'b0);
    drive(to_gray(4'd9), 1'b1, 1'b0, "gate_hold", 4'd9, 4'd4, 1'b0, 1'b0);

    // Illegal jump 0001 -> 0111, then legal steps 0101, 0100; err_out is sticky.
    clear_cycles(1, 4'b0000, "clr_err");
    drive(4'b0001, 1'b1, 1'b0, "err_seq0", 4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, "err_seq1", 4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, "err_seq2", 4'd1, 4'd1, 1'b1, 1'b0);
    drive(4'b0111, 1'b1, 1'b0, "err_jump", 4'd1, 4'd1, 1'b0, 1'b0);
    drive(4'b0101, 1'b1, 1'b0, "err_seq4", 4'd1, 4'd1, 1'b0, 1'b0);
    drive(4'b0100, 1'b1, 1'b0, "err_rise", 4'd5, 4'd4, 1'b1, 1'b1);
    drive(4'b0100, 1'b1, 1'b0, "err_stick", 4'd6, 4'd1, 1'b1, 1'b1);
    drive(4'b0100, 1'b1, 1'b0, "err_stick", 4'd7, 4'd1, 1'b1, 1'b1);
    drive(4'b0100, 1'b1, 1'b0, "err_stick", 4'd7, 4'd1, 1'b0, 1'b1);
    clear_cycles(1, 4'b0100, "err_clr");
    ramp("err_after", 3, 1);

    // Clear mid-stream at bin 12 with the remote pointer still live, then resume.
    clear_cycles(1, 4'b0000, "clr_mid");
    ramp("mid_pre", 12, 2);
    clear_cycles(1, to_gray(4'd13), "mid_clr");
    ramp("mid_resume", 6, 1);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_ptr_receiver.md
# gray_ptr_receiver

Receiving end of a gray-coded pointer crossing. Samples a gray pointer produced by a gray counter in another clock domain, synchronizes it through two flops, checks that it moves by at most one bit per sample, and decodes it back to binary. Outputs the binary pointer and the number of steps it advanced since the last update, for use by FIFO full/empty and occupancy logic in the local domain.

## Interface
- counter_width, 4, pointer width W in bits (≥2); must match the remote gray counter
- clk  input  1  local clock; all state updates on posedge
- clr_in  input  1  synchronous active-high reset
- gray_in  input  W  gray pointer from the remote domain; asynchronous to clk
- en_in  input  1  update enable for the decode/output stage
- gray_sync_out  output  W  synchronized gray pointer, registered
- bin_out  output  W  decoded binary pointer, registered
- step_out  output  W  binary advance since the previous enabled update, modulo 2^W
- step_valid_out  output  1  single-cycle pulse: the pointer changed at the last enabled update
- err_out  output  1  sticky: two consecutive synchronized samples differed in more than one bit

## Operation
- Synchronizer: s1 <= gray_in and s2 <= s1 on every edge. en_in does not gate them. s3 <= s2 on every edge; s3 is the previous sample, used only for the error check.
- Error check runs on every edge, independent of en_in. If popcount(s2 ^ s3) > 1, set err_out to 1. err_out stays 1 until clr_in.
- Decode is combinational from s2:
  - b[W-1] = s2[W-1]
  - b[i] = b[i+1] ^ s2[i], for i from W-2 down to 0
- Update stage, on an edge with en_in = 1:
  - gray_sync_out <= s2
  - bin_out <= b
  - step_out <= (b - bin_out) mod 2^W, where bin_out is the value before this edge
  - step_valid_out <= (s2 != gray_sync_out)
- Edge with en_in = 0:
  - gray_sync_out, bin_out and step_out hold
  - step_valid_out <= 0
  - Because bin_out holds, the next enabled update's step_out covers the whole advance made while disabled.
- Wrap-around: the subtraction is modulo 2^W. Example, W=4: bin_out 15 -> 0 gives step_out 1. The block does not track more than 2^W-1 steps between updates.
- clr_in takes priority over en_in and over the error check.

## Timing
- Reset (clr_in = 1 at an edge): s1, s2, s3, gray_sync_out, bin_out and step_out are all 0; step_valid_out = 0; err_out = 0.
- The all-zero reset state matches the remote counter's reset value (gray 0 = binary 0).
- Latency: a gray_in value that is stable and meets setup before edge k is in s1 after k and in s2 after k+1. With en_in = 1 at k+2, it appears on gray_sync_out / bin_out after edge k+2, a 3-edge latency. step_valid_out is asserted in that same cycle.
- The error check compares s2 against s3, so a bad transition is flagged on the edge after it reaches s2: err_out rises 3 edges after the offending sample edge.
- Throughput: one update per clk. A remote pointer that advances one step per local cycle gives step_out = 1 with step_valid_out high every cycle.
- Clear mid-operation: all registers are zero on the next edge.
  - The first samples after clear are compared against 0. A nonzero remote pointer therefore produces one step_out equal to its binary value.
  - It can also raise err_out through the s2/s3 check if the value is multi-bit. The owner must clear both domains together.
- The first two edges after clear shift the still-live gray_in into s1/s2. No output is guaranteed meaningful until 3 edges after clr_in deasserts.

## Test plan
- Reset: drive clr_in = 1 with gray_in = 4'b0110 for 2 cycles -> all outputs 0, err_out 0. Release with en_in = 1 -> after 3 edges bin_out = 4, step_out = 4, step_valid_out = 1.
- Count sequence (W=4): gray_in walks the full gray sequence 0 -> 1 -> 3 -> 2 -> 6 ..., one step per clk, wrapping 4'b1000 -> 4'b0000.
  - bin_out follows 0..15 then 0 with a 3-edge lag.
  - step_out = 1 every cycle, including across the wrap.
  - err_out stays 0.
- Enable gating: en_in = 0 while gray_in advances from bin 5 to bin 9.
  - During the gap: bin_out holds 5, step_valid_out = 0.
  - On re-enable: bin_out = 9, step_out = 4, step_valid_out = 1.
  - err_out stays 0.
- Stall: gray_in held at bin 7 with en_in = 1 -> step_valid_out = 0, bin_out = 7, step_out holds its last value.
- Multi-bit error: gray_in jumps 4'b0001 -> 4'b0111.
  - err_out = 1 three edges later and stays 1 through later legal steps.
  - A clr_in pulse clears it to 0.
- Clear mid-stream: assert clr_in while bin_out = 12 -> next edge all outputs 0. Resume the walk from gray 0 and check normal counting with err_out 0.
